dma_seq2: RTL and testbench

DMA_SEQ2 -- requirements
Module: dma_seq2

---
 rtl/dma_seq2.sv | 102 ++++++++++
 tb/tb_dma_seq2.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_seq2.sv
// dma_seq2: REU-style DMA sequencer (C64->REU, REU->C64, swap, verify) clocked on the falling PHI2 edge.
// Optional shadow-length autoload is enabled by defining DMA_SEQ2_AUTOLOAD_EN.
module dma_seq2 #(
    parameter int LEN_W = 16
) (
    input  logic             PHI2,
    input  logic             RESET,
    input  logic             BA,
    input  logic             Execute,
    input  logic [1:0]       XferType,
    input  logic             FixCA,
    input  logic             FixREUA,
    input  logic             LenLoad,
    input  logic [LEN_W-1:0] LenIn,
    input  logic             Equal,
    input  logic             Autoload,
    output logic             Reload,
    output logic             DMA,
    output logic             DMARW,
    output logic             RAMRD,
    output logic             RAMWR,
    output logic             IncCA,
    output logic             IncREUA,
    output logic             XferEnd,
    output logic             EndOfBlock,
    output logic             VerifyErr,
    output logic [LEN_W-1:0] Len
);
    typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, FLUSH} state_t;
    state_t     state, state_nx;
    logic [1:0] xtype;
    logic       wr_pend, cmp_valid;
    logic       done, last, err, reload;
    logic [LEN_W-1:0] shadow;

`ifdef DMA_SEQ2_AUTOLOAD_EN
    always_ff @(negedge PHI2 or posedge RESET)
        if (RESET) shadow <= '1;
        else if (state == IDLE && LenLoad) shadow <= LenIn;
    assign reload = last && Autoload;
`else
    logic unused_autoload;
    assign unused_autoload = Autoload;
    assign shadow = '1;
    assign reload = 1'b0;
`endif

    always_comb begin
        // Equal reflects the previous compare, so it is meaningless before the first completed verify cycle
        err      = state == RUN_A && xtype == 2'b11 && cmp_valid && !Equal;
        done     = BA && ((state == RUN_A && xtype != 2'b10 && !err) || state == RUN_B);
        last     = done && Len == LEN_W'(1);
        DMA      = state == RUN_A || state == RUN_B;
        DMARW    = state == RUN_A && xtype != 2'b01;
        RAMRD    = state == RUN_A && xtype != 2'b00;
        RAMWR    = state == RUN_B || (wr_pend && (state == RUN_A || state == FLUSH));
        IncCA    = done && !FixCA;
        IncREUA  = !FixREUA && (xtype == 2'b00 ? BA && RAMWR : done);
        XferEnd  = last;
        Reload   = reload;
        state_nx = state;
        case (state)
            IDLE:    state_nx = Execute ? RUN_A : IDLE;
            RUN_A:   if (BA) state_nx = err ? IDLE : xtype == 2'b10 ? RUN_B :
                                        last ? (xtype == 2'b00 ? FLUSH : IDLE) : RUN_A;
            RUN_B:   if (BA) state_nx = last ? IDLE : RUN_A;
            default: if (BA) state_nx = IDLE;
        endcase
    end

    always_ff @(negedge PHI2 or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            xtype      <= 2'b00;
            wr_pend    <= 1'b0;
            cmp_valid  <= 1'b0;
            EndOfBlock <= 1'b0;
            VerifyErr  <= 1'b0;
            Len        <= '1;
        end else begin
            state <= state_nx;
            // a completed C64 read leaves one REU write pending for the next cycle
            if (BA) wr_pend <= state == RUN_A && xtype == 2'b00;
            if (state == IDLE) begin
                if (LenLoad) Len <= LenIn;
                if (Execute) begin
                    xtype      <= XferType;
                    EndOfBlock <= 1'b0;
                    VerifyErr  <= 1'b0;
                    cmp_valid  <= 1'b0;
                end
            end else begin
                if (done && xtype == 2'b11) cmp_valid <= 1'b1;
                if (BA && err) VerifyErr <= 1'b1;
                if (last) begin
                    EndOfBlock <= 1'b1;
                    if (reload) Len <= shadow;
                end else if (done) Len <= Len - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dma_seq2.sv
// tb_dma_seq2: scoreboard-driven bench for dma_seq2 (LEN_W=16 main instance, LEN_W=8 wrap instance).
module tb_dma_seq2;
    typedef struct packed {
        logic        ba;
        logic        eq;
        logic [5:0]  o;
        logic [15:0] len;
    } step_t;

    logic PHI2 = 1'b1, RESET = 1'b1, BA = 1'b1, Execute = 1'b0, FixCA = 1'b0, FixREUA = 1'b0;
    logic LenLoad = 1'b0, Equal = 1'b1, Autoload = 1'b0, Execute8 = 1'b0, LenLoad8 = 1'b0;
    logic [1:0]  XferType = 2'b00;
    logic [15:0] LenIn = '0, Len;
    logic [7:0]  LenIn8 = '0, Len8;
    logic Reload, DMA, DMARW, RAMRD, RAMWR, IncCA, IncREUA, XferEnd, EndOfBlock, VerifyErr;
    logic Reload8, DMA8, DMARW8, RAMRD8, RAMWR8, IncCA8, IncREUA8, XferEnd8, EndOfBlock8, VerifyErr8;
    int n_tests = 0, n_fail = 0;
    int n_ca = 0, n_reua = 0, n_end = 0, n_reua8 = 0, n_end8 = 0;
    step_t sb[$];

    dma_seq2 #(.LEN_W(16)) dut (
        .PHI2(PHI2), .RESET(RESET), .BA(BA), .Execute(Execute), .XferType(XferType),
        .FixCA(FixCA), .FixREUA(FixREUA), .LenLoad(LenLoad), .LenIn(LenIn), .Equal(Equal),
        .Autoload(Autoload), .Reload(Reload), .DMA(DMA), .DMARW(DMARW), .RAMRD(RAMRD),
        .RAMWR(RAMWR), .IncCA(IncCA), .IncREUA(IncREUA), .XferEnd(XferEnd),
        .EndOfBlock(EndOfBlock), .VerifyErr(VerifyErr), .Len(Len)
    );

    dma_seq2 #(.LEN_W(8)) dut8 (
        .PHI2(PHI2), .RESET(RESET), .BA(BA), .Execute(Execute8), .XferType(XferType),
        .FixCA(FixCA), .FixREUA(FixREUA), .LenLoad(LenLoad8), .LenIn(LenIn8), .Equal(Equal),
        .Autoload(Autoload), .Reload(Reload8), .DMA(DMA8), .DMARW(DMARW8), .RAMRD(RAMRD8),
        .RAMWR(RAMWR8), .IncCA(IncCA8), .IncREUA(IncREUA8), .XferEnd(XferEnd8),
        .EndOfBlock(EndOfBlock8), .VerifyErr(VerifyErr8), .Len(Len8)
    );

    always #5 PHI2 = ~PHI2;

    // pulse counters sampled mid-cycle, away from the falling active edge
    always @(posedge PHI2) begin
        n_ca    += int'(IncCA);
        n_reua  += int'(IncREUA);
        n_end   += int'(XferEnd);
        n_reua8 += int'(IncREUA8);
        n_end8  += int'(XferEnd8);
    end

    task automatic tick();
        @(negedge PHI2);
        #1;
    endtask

    task automatic load_len(input logic [15:0] n);
        LenIn = n;
        LenLoad = 1'b1;
        tick();
        LenLoad = 1'b0;
    endtask

    task automatic start(input logic [1:0] t);
        XferType = t;
        Execute = 1'b1;
        tick();
        Execute = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({DMA, DMARW, RAMRD, RAMWR, IncCA, IncREUA, XferEnd, EndOfBlock, VerifyErr, Reload} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000000000",
                     {DMA, DMARW, RAMRD, RAMWR, IncCA, IncREUA, XferEnd, EndOfBlock, VerifyErr, Reload});
        end
        n_tests++;
        if (Len !== 16'hFFFF || Len8 !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_len: got %h/%h want ffff/ff", Len, Len8);
        end
    endtask

    task automatic test_c64_to_reu();
        step_t s;
        int e0;
        logic [5:0] obs;
        load_len(16'd3);
        sb.push_back('{1'b1, 1'b1, 6'b110100, 16'd3});
        sb.push_back('{1'b1, 1'b1, 6'b111110, 16'd2});
        sb.push_back('{1'b1, 1'b1, 6'b111111, 16'd1});
        sb.push_back('{1'b1, 1'b1, 6'b001010, 16'd1});
        e0 = n_end;
        start(2'b00);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            BA = s.ba;
            Equal = s.eq;
            #1;
            obs = {DMA, DMARW, RAMWR, IncCA, IncREUA, XferEnd};
            n_tests++;
            if (obs !== s.o || Len !== s.len) begin
                n_fail++;
                $display("FAIL c2r_step: got %b len %0d want %b len %0d", obs, Len, s.o, s.len);
            end
            tick();
        end
        n_tests++;
        if (DMA !== 1'b0 || Len !== 16'd1 || EndOfBlock !== 1'b1 || n_end - e0 != 1) begin
            n_fail++;
            $display("FAIL c2r_end: got dma %b len %0d eob %b ends %0d want 0 1 1 1",
                     DMA, Len, EndOfBlock, n_end - e0);
        end
    endtask

    task automatic test_swap_stall();
        step_t s;
        int c0;
        logic [5:0] obs;
        load_len(16'd2);
        sb.push_back('{1'b1, 1'b1, 6'b111000, 16'd2});
        sb.push_back('{1'b0, 1'b1, 6'b100100, 16'd2});
        sb.push_back('{1'b0, 1'b1, 6'b100100, 16'd2});
        sb.push_back('{1'b1, 1'b1, 6'b100110, 16'd2});
        sb.push_back('{1'b1, 1'b1, 6'b111000, 16'd1});
        sb.push_back('{1'b1, 1'b1, 6'b100111, 16'd1});
        c0 = n_ca;
        start(2'b10);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            BA = s.ba;
            Equal = s.eq;
            #1;
            obs = {DMA, DMARW, RAMRD, RAMWR, IncCA, XferEnd};
            n_tests++;
            if (obs !== s.o || Len !== s.len) begin
                n_fail++;
                $display("FAIL swap_step: got %b len %0d want %b len %0d", obs, Len, s.o, s.len);
            end
            tick();
        end
        BA = 1'b1;
        n_tests++;
        if (DMA !== 1'b0 || Len !== 16'd1 || EndOfBlock !== 1'b1 || n_ca - c0 != 2) begin
            n_fail++;
            $display("FAIL swap_end: got dma %b len %0d eob %b incca %0d want 0 1 1 2",
                     DMA, Len, EndOfBlock, n_ca - c0);
        end
    endtask

    task automatic test_verify();
        step_t s;
        int c0;
        logic [5:0] obs;
        load_len(16'd5);
        sb.push_back('{1'b1, 1'b1, 6'b111010, 16'd5});
        sb.push_back('{1'b1, 1'b1, 6'b111010, 16'd4});
        sb.push_back('{1'b1, 1'b0, 6'b111000, 16'd3});
        c0 = n_ca;
        start(2'b11);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            BA = s.ba;
            Equal = s.eq;
            #1;
            obs = {DMA, DMARW, RAMRD, RAMWR, IncCA, XferEnd};
            n_tests++;
            if (obs !== s.o || Len !== s.len) begin
                n_fail++;
                $display("FAIL verify_step: got %b len %0d want %b len %0d", obs, Len, s.o, s.len);
            end
            tick();
        end
        Equal = 1'b1;
        n_tests++;
        if (DMA !== 1'b0 || VerifyErr !== 1'b1 || Len !== 16'd3 || EndOfBlock !== 1'b0 || n_ca - c0 != 2) begin
            n_fail++;
            $display("FAIL verify_end: got dma %b verr %b len %0d eob %b incca %0d want 0 1 3 0 2",
                     DMA, VerifyErr, Len, EndOfBlock, n_ca - c0);
        end
    endtask

    task automatic test_load_execute();
        int c0, r0, e0;
        c0 = n_ca;
        r0 = n_reua;
        e0 = n_end;
        FixCA = 1'b1;
        LenIn = 16'd2;
        LenLoad = 1'b1;
        start(2'b01);
        LenLoad = 1'b0;
        n_tests++;
        if (Len !== 16'd2 || DMA !== 1'b1 || EndOfBlock !== 1'b0 || VerifyErr !== 1'b0) begin
            n_fail++;
            $display("FAIL load_exec_start: got len %0d dma %b eob %b verr %b want 2 1 0 0",
                     Len, DMA, EndOfBlock, VerifyErr);
        end
        Execute = 1'b1;
        tick();
        tick();
        Execute = 1'b0;
        #1;
        n_tests++;
        if (DMA !== 1'b0 || Len !== 16'd1 || n_ca - c0 != 0 || n_reua - r0 != 2 || n_end - e0 != 1) begin
            n_fail++;
            $display("FAIL load_exec_end: got dma %b len %0d incca %0d increua %0d ends %0d want 0 1 0 2 1",
                     DMA, Len, n_ca - c0, n_reua - r0, n_end - e0);
        end
        FixCA = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        int e0;
        load_len(16'd4);
        e0 = n_end;
        start(2'b00);
        tick();
        n_tests++;
        if (DMA !== 1'b1 || RAMWR !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: got dma %b ramwr %b want 1 1", DMA, RAMWR);
        end
        #1;
        RESET = 1'b1;
        #1;
        n_tests++;
        if (DMA !== 1'b0 || RAMWR !== 1'b0 || XferEnd !== 1'b0 || Len !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL abort_now: got dma %b ramwr %b xend %b len %h want 0 0 0 ffff",
                     DMA, RAMWR, XferEnd, Len);
        end
        tick();
        RESET = 1'b0;
        tick();
        n_tests++;
        if (n_end - e0 != 0 || DMA !== 1'b0 || RAMWR !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: got ends %0d dma %b ramwr %b want 0 0 0", n_end - e0, DMA, RAMWR);
        end
    endtask

    task automatic test_autoload();
        logic       exp_reload;
        logic [15:0] exp_len;
`ifdef DMA_SEQ2_AUTOLOAD_EN
        exp_reload = 1'b1;
        exp_len = 16'd4;
`else
        exp_reload = 1'b0;
        exp_len = 16'd1;
`endif
        load_len(16'd4);
        Autoload = 1'b1;
        start(2'b01);
        tick();
        tick();
        tick();
        n_tests++;
        if (XferEnd !== 1'b1 || Reload !== exp_reload) begin
            n_fail++;
            $display("FAIL autoload_pulse: got xend %b reload %b want 1 %b", XferEnd, Reload, exp_reload);
        end
        tick();
        Autoload = 1'b0;
        n_tests++;
        if (DMA !== 1'b0 || Len !== exp_len || Reload !== 1'b0) begin
            n_fail++;
            $display("FAIL autoload_len: got dma %b len %0d reload %b want 0 %0d 0", DMA, Len, Reload, exp_len);
        end
    endtask

    task automatic test_len_zero();
        int  r0, e0;
        bit  seen = 0;
        r0 = n_reua8;
        e0 = n_end8;
        XferType = 2'b01;
        LenIn8 = 8'd0;
        LenLoad8 = 1'b1;
        Execute8 = 1'b1;
        tick();
        LenLoad8 = 1'b0;
        Execute8 = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            #1;
            if (XferEnd8) seen = 1;
            tick();
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL len_zero_timeout: got no XferEnd in 300 cycles want XferEnd");
        end
        n_tests++;
        if (n_reua8 - r0 != 256 || n_end8 - e0 != 1 || Len8 !== 8'd1 || DMA8 !== 1'b0) begin
            n_fail++;
            $display("FAIL len_zero: got increua %0d ends %0d len %0d dma %b want 256 1 1 0",
                     n_reua8 - r0, n_end8 - e0, Len8, DMA8);
        end
    endtask

    initial begin
        tick();
        tick();
        RESET = 1'b0;
        test_reset();
        test_c64_to_reu();
        test_swap_stall();
        test_verify();
        test_load_execute();
        test_reset_abort();
        test_autoload();
        test_len_zero();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
